// File: rtl/cbu_arbiter.sv
// Round-robin arbiter sharing one CBU between two requesters.
// It locks the CBU for count instructions and routes each result beat back to its issuer.
module cbu_arbiter #(
    parameter int unsigned CBU_LAT   = 2,
    parameter int unsigned COUNT_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic [8:0] instr0,
    input  logic [8:0] instr1,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [3:0] rdata,
    output logic       busy,
    output logic [8:0] cbu_in,
    output logic [3:0] cbu_a,
    output logic [3:0] cbu_b,
    input  logic [3:0] cbu_out
);
    localparam int unsigned CNT_W = (COUNT_LEN > 2) ? $clog2(COUNT_LEN) : 1;

    typedef enum logic [0:0] {StIssue, StLock} state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_last, w_last_nxt;
    logic             r_owner, w_owner_nxt;
    logic [8:0]       r_in, w_in_nxt;
    logic [3:0]       r_a, w_a_nxt;
    logic [3:0]       r_b, w_b_nxt;
    // Stage 0 travels alongside the cbu_in register; the last stage lines up with cbu_out.
    logic [CBU_LAT:0] r_tag_v, r_tag_id;
    logic             w_tag_v, w_tag_id;

    logic             w_win1, w_xfer, w_is_count;
    logic [8:0]       w_instr;
    logic [3:0]       w_a, w_b;

    // r_last holds the id granted most recently; the other side wins a tie.
    assign w_win1     = req1 & (~req0 | ~r_last);
    assign w_instr    = w_win1 ? instr1 : instr0;
    assign w_a        = w_win1 ? a1 : a0;
    assign w_b        = w_win1 ? b1 : b0;
    assign w_is_count = (w_instr[8:6] == 3'b101) | (w_instr[8:6] == 3'b110);
    assign w_xfer     = (r_state == StIssue) & (req0 | req1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_in_nxt    = 9'd0;
        w_a_nxt     = 4'd0;
        w_b_nxt     = 4'd0;
        w_tag_v     = 1'b0;
        w_tag_id    = 1'b0;
        case (r_state)
            StIssue: begin
                if (w_xfer) begin
                    w_in_nxt   = w_instr;
                    w_a_nxt    = w_a;
                    w_b_nxt    = w_b;
                    w_tag_v    = 1'b1;
                    w_tag_id   = w_win1;
                    w_last_nxt = w_win1;
                    if (w_is_count && COUNT_LEN > 1) begin
                        w_state_nxt = StLock;
                        w_cnt_nxt   = CNT_W'(COUNT_LEN - 1);
                        w_owner_nxt = w_win1;
                    end
                end
            end
            StLock: begin
                w_in_nxt  = r_in;
                w_a_nxt   = r_a;
                w_b_nxt   = r_b;
                w_tag_v   = 1'b1;
                w_tag_id  = r_owner;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = StIssue;
                end
            end
            default: w_state_nxt = StIssue;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIssue;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_in     <= 9'd0;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_owner  <= w_owner_nxt;
            r_in     <= w_in_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_tag_v  <= {r_tag_v[CBU_LAT-1:0], w_tag_v};
            r_tag_id <= {r_tag_id[CBU_LAT-1:0], w_tag_id};
        end
    end

    assign gnt0    = rst & (r_state == StIssue) & req0 & ~w_win1;
    assign gnt1    = rst & (r_state == StIssue) & w_win1;
    assign busy    = (r_state == StLock);
    assign rvalid0 = rst & r_tag_v[CBU_LAT] & ~r_tag_id[CBU_LAT];
    assign rvalid1 = rst & r_tag_v[CBU_LAT] & r_tag_id[CBU_LAT];
    assign rdata   = cbu_out;
    assign cbu_in  = r_in;
    assign cbu_a   = r_a;
    assign cbu_b   = r_b;

endmodule

// File: doc/cbu_arbiter.md
Name: cbu_arbiter

Overview:
- Shares one CBU (9-bit instruction, 4-bit a/b operands, 4-bit registered result) between two requesters.
- Arbitrates round-robin and registers the selected instruction/operands onto the CBU inputs.
- Tracks ownership of every in-flight CBU beat and routes each result back to the requester that issued it.
- Count instructions (opcodes 101 up, 110 down) produce one result per cycle while held, so the arbiter locks the CBU to their owner for COUNT_LEN cycles.

Parameters:
- CBU_LAT, 2, edges from CBU input capture to result visible on cbu_out.
- COUNT_LEN, 16, cycles a count instruction is held on the CBU (one result per cycle).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req0, req1  input  1  requester valid; instr/a/b held stable while high.
- gnt0, gnt1  output  1  combinational ready; a transfer occurs at an edge with reqN&gntN.
- instr0, instr1  input  9  instruction: [8:6] opcode, [5:0] passed through unchanged.
- a0, a1, b0, b1  input  4  operands.
- rvalid0, rvalid1  output  1  result beat for that requester is on rdata.
- rdata  output  4  equals cbu_out (shared; qualified by rvalidN).
- busy  output  1  count lock active.
- cbu_in  output  9  registered CBU instruction.
- cbu_a, cbu_b  output  4  registered CBU operands.
- cbu_out  input  4  CBU result.

Behaviour:
- Reset (rst=0, async): cbu_in/cbu_a/cbu_b=0, tag pipe cleared, lock counter=0, busy=0, RR pointer favours requester 0. gnt0/gnt1/rvalid0/rvalid1=0 while in reset.
- Reset asserted mid-count or mid-pipe aborts everything. No rvalid is produced for beats in flight.
- States:
  - IDLE/ISSUE (busy=0): gnt asserted to the arbitration winner among active reqs, one transfer max per cycle.
  - LOCK (busy=1): gnt0=gnt1=0.
- Arbitration: only one req → that one wins. Both → the requester not granted most recently wins. The pointer updates only on a transfer.
- On transfer at edge E0: cbu_in/a/b ← winner's instr/a/b. A tag {valid=1, id} enters stage 0 of a CBU_LAT-deep shift pipe.
- rvalidN=1 in the cycle after edge E0+CBU_LAT when the tag at the last stage has id=N. Single ops are fully pipelined: back-to-back accepts give back-to-back rvalids.
- Cycles with no transfer and no lock:
  - cbu_in/a/b ← 0 (add 0+0).
  - An invalid tag enters the pipe; no rvalid is produced.
- Count transfer (opcode 101 or 110) at E0:
  - Enter LOCK with counter=COUNT_LEN-1.
  - cbu_in/a/b are held for edges E0..E0+COUNT_LEN-1, each edge pushing a valid tag for the owner.
  - busy=1 from after E0 until after E0+COUNT_LEN-1, i.e. COUNT_LEN-1 cycles.
  - Next transfer possible at edge E0+COUNT_LEN, then returns to ISSUE.
  - Owner receives exactly COUNT_LEN consecutive rvalid beats.
- A pending req of either requester is never dropped and waits through LOCK. At lock exit, normal RR applies (owner is most-recent, so the other wins a tie).
- The arbiter never modifies instr bits or operands; arithmetic and wrap-around are the CBU's (4-bit modulo).
- The tag pipe drains independently of arbitration. Results of single ops issued before a count still return in order before count beats.

Test Plan:
- Reset: hold rst=0 with req0=req1=1 → gnt0=gnt1=0, cbu_in=0, rvalid=0. Release → gnt0=1 first.
- Single op: req0 instr=000011011 a=6 b=3 accepted at E0 → rvalid0=1, rdata=9 in the cycle after E2. rvalid1 stays 0.
- Round-robin: req0 and req1 both high for 4 cycles (add 10+7, sub 7-2) → grants alternate 0,1,0,1. Results alternate rvalid0 rdata=1, rvalid1 rdata=5 on consecutive cycles.
- Count lock: req1 instr=101000011 accepted, with req0 pending add → gnt0 low for 15 cycles, busy=1.
  - Exactly 16 rvalid1 beats with rdata 0..15.
  - req0 is then granted at edge E0+16, and its result follows.
- Pipe ordering: req0 single op 3++ (010010010, a=3) accepted, then req1 count-down accepted on the next edge → rvalid0 rdata=4 first, then 16 rvalid1 beats 0,15,14..1.
- Reset mid-lock: assert rst=0 at count beat 5 → busy=0 and no further rvalid. After release, a new req1 add is granted immediately.
